// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control path.
//   - ALUOp encodings, forwarding-select encodings, opcode constants
//   - ctrl_t: 11-bit packed control bundle carried down the pipeline
package ctrl_pkg;

   // ALUOp
   localparam logic [1:0] ALU_ADD  = 2'b10;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b00;
   localparam logic [1:0] ALU_ANDX = 2'b11;   // AND / XOR

   // Forwarding selects for ALU operands
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Opcodes (MIPS-style, 6 bits)
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_J     = 6'h02;

   // vld marks a real instruction; a bubble is the all-zero bundle.
   typedef struct packed {
      logic       vld;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_sel.sv
// fwd_sel: combinational forwarding comparator for one ALU operand.
//   src_i      - register read by the instruction in EX
//   mem_rw_i   - RegWrite of the instruction in MEM, mem_dest_i its destination
//   wb_rw_i    - RegWrite of the instruction in WB,  wb_dest_i its destination
//   sel_o      - FWD_MEM / FWD_WB / FWD_REG; MEM has priority (newer value)
module fwd_sel
   import ctrl_pkg::*;
#(
   parameter int RA_W = 5
)(
   input  logic [RA_W-1:0] src_i,
   input  logic            mem_rw_i,
   input  logic [RA_W-1:0] mem_dest_i,
   input  logic            wb_rw_i,
   input  logic [RA_W-1:0] wb_dest_i,
   output logic [1:0]      sel_o
);

   // r0 is hardwired zero, so it is never a forwarding source.
   always_comb begin
      sel_o = FWD_REG;
      if (wb_rw_i && (wb_dest_i != '0) && (wb_dest_i == src_i))
         sel_o = FWD_WB;
      if (mem_rw_i && (mem_dest_i != '0) && (mem_dest_i == src_i))
         sel_o = FWD_MEM;
   end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: control half of the ID/EX, EX/MEM, MEM/WB pipeline
// registers, plus load-use stall, branch/jump flush and EX forwarding selects.
//   Inputs : clk, reset (async, active high), id_* decoded control and register
//            fields of the instruction in ID, ex_zero from the ALU.
//   Outputs: pc_write, ifid_write, ifid_flush (fetch control),
//            ex_*/mem_*/wb_* stage controls, *_dest per stage, fwd_a/fwd_b.
// Optional: define CTRL_PIPE_PERF_CNT_EN to add saturating stall_cnt and
//           flush_cnt outputs (CNT_W bits each).
module ctrl_pipe_hazard
   import ctrl_pkg::*;
#(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            id_reg_dst,
   input  logic            id_alu_src,
   input  logic            id_mem_to_reg,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_branch,
   input  logic            id_jump,
   input  logic [1:0]      id_alu_op,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic [RA_W-1:0] id_rd,
   input  logic            ex_zero,
   output logic            pc_write,
   output logic            ifid_write,
   output logic            ifid_flush,
   output logic            ex_alu_src,
   output logic [1:0]      ex_alu_op,
   output logic [RA_W-1:0] ex_rs,
   output logic [RA_W-1:0] ex_rt,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic            wb_reg_write,
   output logic            wb_mem_to_reg,
   output logic [RA_W-1:0] ex_dest,
   output logic [RA_W-1:0] mem_dest,
   output logic [RA_W-1:0] wb_dest,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
`ifdef CTRL_PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   ctrl_t           id_ctrl, ex_d, ex_q, mem_q, wb_q;
   logic [RA_W-1:0] ex_rs_d, ex_rt_d, ex_dest_d;
   logic [RA_W-1:0] ex_rs_q, ex_rt_q, ex_dest_q, mem_dest_q, wb_dest_q;
   logic            br_taken, luh, bubble;

   always_comb begin
      id_ctrl = '{vld: 1'b1, reg_dst: id_reg_dst, alu_src: id_alu_src,
                  mem_to_reg: id_mem_to_reg, reg_write: id_reg_write,
                  mem_read: id_mem_read, mem_write: id_mem_write,
                  branch: id_branch, jump: id_jump, alu_op: id_alu_op};
   end

   // A jump in ID is flushed behind it anyway, so it never needs to stall.
   assign br_taken = ex_q.branch & ex_zero;
   assign luh      = ex_q.mem_read & (ex_dest_q != '0) & ~id_jump &
                     ((ex_dest_q == id_rs) | (ex_dest_q == id_rt));
   assign bubble   = br_taken | luh;

   // A taken branch overrides the stall: the stalled instruction is squashed.
   assign pc_write   = ~luh | br_taken;
   assign ifid_write = ~luh | br_taken;
   assign ifid_flush = br_taken | id_jump;

   always_comb begin
      ex_d      = id_ctrl;
      ex_rs_d   = id_rs;
      ex_rt_d   = id_rt;
      ex_dest_d = id_reg_dst ? id_rd : id_rt;
      if (bubble) begin
         ex_d      = '0;
         ex_rs_d   = '0;
         ex_rt_d   = '0;
         ex_dest_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_dest_q  <= '0;
         mem_dest_q <= '0;
         wb_dest_q  <= '0;
      end else begin
         ex_q       <= ex_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_dest_q  <= ex_dest_d;
         mem_q      <= ex_q;
         mem_dest_q <= ex_dest_q;
         wb_q       <= mem_q;
         wb_dest_q  <= mem_dest_q;
      end
   end

   assign ex_alu_src    = ex_q.alu_src;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_rs         = ex_rs_q;
   assign ex_rt         = ex_rt_q;
   assign mem_mem_read  = mem_q.mem_read;
   assign mem_mem_write = mem_q.mem_write;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_mem_to_reg = wb_q.mem_to_reg;
   assign ex_dest       = ex_dest_q;
   assign mem_dest      = mem_dest_q;
   assign wb_dest       = wb_dest_q;

   // Only RegWrite/MemToReg are consumed in WB; the rest of the bundle ends here.
   logic unused_wb;
   assign unused_wb = ^wb_q;

   fwd_sel #(.RA_W(RA_W)) u_fwd_a (
      .src_i(ex_rs_q), .mem_rw_i(mem_q.reg_write), .mem_dest_i(mem_dest_q),
      .wb_rw_i(wb_q.reg_write), .wb_dest_i(wb_dest_q), .sel_o(fwd_a)
   );

   fwd_sel #(.RA_W(RA_W)) u_fwd_b (
      .src_i(ex_rt_q), .mem_rw_i(mem_q.reg_write), .mem_dest_i(mem_dest_q),
      .wb_rw_i(wb_q.reg_write), .wb_dest_i(wb_dest_q), .sel_o(fwd_b)
   );

`ifdef CTRL_PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (luh && !br_taken && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (ifid_flush && !(&flush_cnt_q))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   localparam int CNT_W_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
module tb_ctrl_pipe_hazard;
   localparam int RA_W = 5;
   localparam int CNT_W = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
   logic id_mem_read, id_mem_write, id_branch, id_jump;
   logic [1:0] id_alu_op;
   logic [RA_W-1:0] id_rs, id_rt, id_rd;
   logic ex_zero;
   logic pc_write, ifid_write, ifid_flush, ex_alu_src;
   logic [1:0] ex_alu_op;
   logic [RA_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
   logic mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
   logic [1:0] fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   ctrl_pipe_hazard #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef CTRL_PIPE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Reference model: one record per occupied stage, a bubble is all zero.
   typedef struct {
      int rw, mtr, mr, mw, br, asrc, aop, rs, rt, dest;
   } ent_t;

   ent_t m_ex, m_mem, m_wb;
   int   m_stall, m_flush;
   int   total = 0;
   int   bad = 0;

   function automatic ent_t bub();
      ent_t e;
      e = '{default: 0};
      return e;
   endfunction

   task automatic model_reset();
      m_ex = bub(); m_mem = bub(); m_wb = bub();
      m_stall = 0; m_flush = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int fwd(input int r);
      if (m_mem.rw != 0 && m_mem.dest != 0 && m_mem.dest == r) return 2;
      if (m_wb.rw != 0 && m_wb.dest != 0 && m_wb.dest == r) return 1;
      return 0;
   endfunction

   function automatic bit model_br();
      return m_ex.br != 0 && ex_zero === 1'b1;
   endfunction

   function automatic bit model_luh();
      return m_ex.mr != 0 && m_ex.dest != 0 && id_jump !== 1'b1 &&
             (m_ex.dest == int'(id_rs) || m_ex.dest == int'(id_rt));
   endfunction

   task automatic set_id(input bit rdst, asrc, mtr, rw, mr, mw, br, jmp,
                         input int aop, rs, rt, rd);
      id_reg_dst = rdst; id_alu_src = asrc; id_mem_to_reg = mtr; id_reg_write = rw;
      id_mem_read = mr; id_mem_write = mw; id_branch = br; id_jump = jmp;
      id_alu_op = 2'(aop); id_rs = RA_W'(rs); id_rt = RA_W'(rt); id_rd = RA_W'(rd);
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".ex_alu_src"}, 32'(ex_alu_src), 32'(m_ex.asrc));
      chk({tag, ".ex_alu_op"}, 32'(ex_alu_op), 32'(m_ex.aop));
      chk({tag, ".ex_rs"}, 32'(ex_rs), 32'(m_ex.rs));
      chk({tag, ".ex_rt"}, 32'(ex_rt), 32'(m_ex.rt));
      chk({tag, ".ex_dest"}, 32'(ex_dest), 32'(m_ex.dest));
      chk({tag, ".mem_mem_read"}, 32'(mem_mem_read), 32'(m_mem.mr));
      chk({tag, ".mem_mem_write"}, 32'(mem_mem_write), 32'(m_mem.mw));
      chk({tag, ".mem_dest"}, 32'(mem_dest), 32'(m_mem.dest));
      chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(m_wb.rw));
      chk({tag, ".wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(m_wb.mtr));
      chk({tag, ".wb_dest"}, 32'(wb_dest), 32'(m_wb.dest));
      chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fwd(m_ex.rs)));
      chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fwd(m_ex.rt)));
`ifdef CTRL_PIPE_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`endif
   endtask

   // One clock: check fetch controls for the current ID, clock, advance model.
   task automatic step(input string tag, input bit do_checks = 1);
      bit   br, luh;
      ent_t nx;
      #1;
      br  = model_br();
      luh = model_luh();
      if (do_checks) begin
         chk({tag, ".pc_write"}, 32'(pc_write), 32'(!luh || br));
         chk({tag, ".ifid_write"}, 32'(ifid_write), 32'(!luh || br));
         chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(br || id_jump === 1'b1));
      end
      nx = bub();
      if (!(br || luh)) begin
         nx.rw = id_reg_write; nx.mtr = id_mem_to_reg; nx.mr = id_mem_read;
         nx.mw = id_mem_write; nx.br = id_branch; nx.asrc = id_alu_src;
         nx.aop = int'(id_alu_op); nx.rs = int'(id_rs); nx.rt = int'(id_rt);
         nx.dest = id_reg_dst ? int'(id_rd) : int'(id_rt);
      end
      @(posedge clk);
      if (luh && !br && m_stall < CNT_MAX) m_stall++;
      if ((br || id_jump === 1'b1) && m_flush < CNT_MAX) m_flush++;
      m_wb = m_mem; m_mem = m_ex; m_ex = nx;
      #1;
      if (do_checks) check_regs(tag);
   endtask

   initial begin
      model_reset();
      reset = 1'b1; ex_zero = 1'b0;
      nop();
      #12;
      check_regs("rst");
      chk("rst.pc_write", 32'(pc_write), 32'd1);
      chk("rst.ifid_write", 32'(ifid_write), 32'd1);
      chk("rst.ifid_flush", 32'(ifid_flush), 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // 1: async reset with a load in WB and another in MEM
      set_id(0, 1, 1, 1, 1, 0, 0, 0, 2, 1, 4, 0); step("t1a");      // lw r4
      set_id(0, 1, 1, 1, 1, 0, 0, 0, 2, 1, 5, 0); step("t1b");      // lw r5
      nop(); step("t1c");
      chk("t1.wb_rw_pre", 32'(wb_reg_write), 32'd1);
      chk("t1.mem_mr_pre", 32'(mem_mem_read), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t1.wb_rw_async", 32'(wb_reg_write), 32'd0);
      chk("t1.mem_mr_async", 32'(mem_mem_read), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("t1.pc_write", 32'(pc_write), 32'd1);
      check_regs("t1.post");
      @(posedge clk); #1;

      // 2: load-use stall, then MEM/WB forwarding
      set_id(0, 1, 1, 1, 1, 0, 0, 0, 2, 1, 2, 0); step("t2a");      // lw r2
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 2, 5, 7);                   // add r7,r2,r5
      #1 chk("t2.stall_pc", 32'(pc_write), 32'd0);
      chk("t2.stall_ifid", 32'(ifid_write), 32'd0);
      step("t2b");
      chk("t2.bubble_rw", 32'(dut.ex_q.reg_write), 32'd0);
      chk("t2.bubble_src", 32'(ex_alu_src), 32'd0);
      step("t2c");                                                   // ID held
      chk("t2.fwd_a", 32'(fwd_a), 32'd1);
      chk("t2.ex_rs", 32'(ex_rs), 32'd2);

      // 2b: reset during a stall leaves no residual stall
      nop(); step("t2d"); step("t2e");
      set_id(0, 1, 1, 1, 1, 0, 0, 0, 2, 1, 3, 0); step("t2f");      // lw r3
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 3, 3, 8);
      #1 chk("t2.stall2", 32'(pc_write), 32'd0);
      reset = 1'b1;
      #1 chk("t2.rst_nostall", 32'(pc_write), 32'd1);
      model_reset();
      @(posedge clk); #1 reset = 1'b0;
      step("t2g");

      // 3: MEM beats WB
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 3); step("t3a");      // add r3
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 2, 2, 3); step("t3b");      // add r3
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 3, 3, 9); step("t3c");      // add r9,r3,r3
      chk("t3.fwd_a", 32'(fwd_a), 32'd2);
      chk("t3.fwd_b", 32'(fwd_b), 32'd2);

      // 4: r0 never stalls or forwards
      set_id(0, 1, 1, 1, 1, 0, 0, 0, 2, 1, 0, 0); step("t4a");      // lw r0
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 6);
      #1 chk("t4.pc_write", 32'(pc_write), 32'd1);
      step("t4b");
      nop(); step("t4c");
      chk("t4.fwd_a", 32'(fwd_a), 32'd0);
      chk("t4.fwd_b", 32'(fwd_b), 32'd0);

      // 5: taken branch wins over load-use; not taken -> stall
      set_id(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 6, 0); step("t5a");      // br+mr, dest r6
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 6, 1, 7);
      ex_zero = 1'b1;
      #1 chk("t5.flush", 32'(ifid_flush), 32'd1);
      chk("t5.pc_write", 32'(pc_write), 32'd1);
      step("t5b");
      chk("t5.bubble_rs", 32'(ex_rs), 32'd0);
      ex_zero = 1'b0;
      set_id(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 6, 0); step("t5c");
      set_id(1, 0, 0, 1, 0, 0, 0, 0, 2, 6, 1, 7);
      #1 chk("t5.nt_stall", 32'(pc_write), 32'd0);
      chk("t5.nt_flush", 32'(ifid_flush), 32'd0);
      step("t5d");

      // 6: jump flushes one cycle, no stall
      nop(); step("t6a");
      set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1 chk("t6.flush", 32'(ifid_flush), 32'd1);
      chk("t6.pc_write", 32'(pc_write), 32'd1);
      step("t6b");
      nop();
      #1 chk("t6.flush_off", 32'(ifid_flush), 32'd0);
      step("t6c");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (pc_write === 1'b1) begin
            set_id(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
         ex_zero = 1'($urandom);
         step("rnd");
      end

`ifdef CTRL_PIPE_PERF_CNT_EN
      // Flush counter saturation
      ex_zero = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < CNT_MAX + 4; i++) step("sat", 1'b0);
      check_regs("sat");
      chk("sat.flush_cnt", 32'(flush_cnt), 32'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
